// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the destinations of the instructions in EX and MEM
// and stalls loads feeding their consumers, flushing IF/ID on a taken redirect.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RS_ID,
    input  logic [4:0]  RT_ID,
    input  logic        UseRS_ID,
    input  logic        UseRT_ID,
    input  logic        RegWrite_ID,
    input  logic        MemRead_ID,
    input  logic [4:0]  WriteReg_ID,
    input  logic        Branch_ID,
    input  logic        Taken_ID,
    output logic        Stall_IF,
    output logic        Stall_ID,
    output logic        Flush_DE,
    output logic        Flush_FD,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;

    // Slot 0 mirrors ID/EX, slot 1 mirrors EX/MEM.
    logic [1:0] valid_reg;
    logic [1:0] regwrite_reg;
    logic [1:0] memread_reg;
    logic [4:0] writereg_reg [2];

    logic [31:0] stall_count_reg;
    logic [31:0] flush_count_reg;

    logic [1:0] load_hit;
    logic       stall;
    logic       flush_fd;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            // A pending load whose destination is a register the ID instruction really reads.
            assign load_hit[gi] = valid_reg[gi] && regwrite_reg[gi] && memread_reg[gi]
                                && (writereg_reg[gi] != 5'd0)
                                && ((UseRS_ID && (writereg_reg[gi] == RS_ID))
                                 || (UseRT_ID && (writereg_reg[gi] == RT_ID)));
        end
    endgenerate

    // Branches compare in ID, so a load still in MEM cannot be forwarded to them yet.
    assign stall    = !rst && (load_hit[SLOT_EX] || (Branch_ID && load_hit[SLOT_MEM]));
    assign flush_fd = !rst && Taken_ID && !stall;

    assign Stall_IF   = stall;
    assign Stall_ID   = stall;
    assign Flush_DE   = stall;
    assign Flush_FD   = flush_fd;
    assign StallCount = stall_count_reg;
    assign FlushCount = flush_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg       <= 2'b00;
            regwrite_reg    <= 2'b00;
            memread_reg     <= 2'b00;
            stall_count_reg <= 32'd0;
            flush_count_reg <= 32'd0;
        end else begin
            valid_reg[SLOT_MEM]    <= valid_reg[SLOT_EX];
            regwrite_reg[SLOT_MEM] <= regwrite_reg[SLOT_EX];
            memread_reg[SLOT_MEM]  <= memread_reg[SLOT_EX];
            writereg_reg[SLOT_MEM] <= writereg_reg[SLOT_EX];

            // A stalled instruction stays in ID; EX receives a bubble.
            valid_reg[SLOT_EX]     <= !stall;
            regwrite_reg[SLOT_EX]  <= RegWrite_ID;
            memread_reg[SLOT_EX]   <= MemRead_ID;
            writereg_reg[SLOT_EX]  <= WriteReg_ID;

            if (stall)
                stall_count_reg <= stall_count_reg + 32'd1;
            if (flush_fd)
                flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

endmodule
